// File: rtl/idct_out_reorder.sv
// idct_out_reorder: ping-pong reorder of IFFT output into interleaved IDCT samples x1(2i)=x(i), x1(2i+1)=x(N-1-i)
// Ports: clk/rst (async, active-high); sink_* = natural-order IFFT stream with sop/eop framing and
// block length fftpts_in (sampled on sop); source_* = reordered stream with sop/eop framing.
// Optional macro IDCT_REORDER_ERR_EN adds the sticky source_error output and the sink_imag range check.
module idct_out_reorder #(
  parameter int wDataIn  = 18,
  parameter int wDataOut = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sink_valid,
  input  logic                sink_sop,
  input  logic                sink_eop,
  input  logic [wDataIn-1:0]  sink_real,
  input  logic [wDataIn-1:0]  sink_imag,
  input  logic [11:0]         fftpts_in,
  output logic                source_valid,
  output logic                source_sop,
  output logic                source_eop,
  output logic [wDataOut-1:0] source_real
`ifdef IDCT_REORDER_ERR_EN
  ,
  output logic                source_error
`endif
);
  typedef enum logic {W_IDLE, W_FILL} wstate_t;
  typedef enum logic {R_IDLE, R_OUT} rstate_t;
  wstate_t wstate;
  rstate_t rstate;
  logic [wDataOut-1:0] mem [0:4095];
  logic [wDataOut-1:0] q, din;
  logic [1:0] full;
  logic wsel, rsel;
  logic [10:0] wcnt, m, n_m1, nw_m1, nr_m1, ra, wa;
  logic [10:0] nb_m1 [2];
  logic sop_beat, we, last, re, rd_last;
  generate
    if (wDataOut > wDataIn) begin : g_ext
      assign din = {{(wDataOut-wDataIn){sink_real[wDataIn-1]}}, sink_real};
    end else begin : g_trunc
      assign din = sink_real[wDataIn-1 -: wDataOut];
    end
  endgenerate
  // Block lengths are held as N-1 so every counter and address stays 11 bits wide.
  always_comb n_m1 = (fftpts_in inside {12'd32, 12'd64, 12'd128, 12'd256, 12'd512, 12'd1024, 12'd2048})
                     ? 11'(fftpts_in - 12'd1) : 11'd2047;
  // A sop while filling restarts the block at address 0; a sop on a full bank drops the block.
  always_comb begin
    sop_beat = sink_valid & sink_sop;
    we       = sink_valid & ((wstate == W_FILL) | (sink_sop & ~full[wsel]));
    wa       = sink_sop ? 11'd0 : wcnt;
    last     = (wstate == W_FILL) & sink_valid & ~sink_sop & (wcnt == nw_m1);
    rd_last  = (rstate == R_OUT) & (m == nr_m1);
    re       = (rstate == R_OUT) | full[rsel];
    ra       = (rstate == R_IDLE) ? 11'd0 : m[0] ? nr_m1 - {1'b0, m[10:1]} : {1'b0, m[10:1]};
  end
  always_ff @(posedge clk) begin
    if (we) mem[{wsel, wa}] <= din;
    if (re) q <= mem[{rsel, ra}];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate   <= W_IDLE;
      wsel     <= 1'b0;
      wcnt     <= '0;
      nw_m1    <= 11'd2047;
      nb_m1[0] <= 11'd2047;
      nb_m1[1] <= 11'd2047;
    end else if (sop_beat) begin
      nw_m1 <= n_m1;
      if (we) begin
        wcnt   <= 11'd1;
        wstate <= W_FILL;
      end
    end else if (wstate == W_FILL && sink_valid) begin
      if (last) begin
        nb_m1[wsel] <= nw_m1;
        wsel        <= ~wsel;
        wstate      <= W_IDLE;
      end else wcnt <= wcnt + 11'd1;
    end
  end
  // Set and clear always target different banks: a bank being read is full, a bank being written is not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) full <= '0;
    else begin
      if (last) full[wsel] <= 1'b1;
      if (rd_last) full[rsel] <= 1'b0;
    end
  end
  // The idle cycle that discovers a full bank already issues read 0, giving the two-cycle latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate       <= R_IDLE;
      rsel         <= 1'b0;
      m            <= '0;
      nr_m1        <= '0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
    end else if (rstate == R_IDLE) begin
      source_valid <= full[rsel];
      source_sop   <= full[rsel];
      source_eop   <= 1'b0;
      if (full[rsel]) begin
        nr_m1  <= nb_m1[rsel];
        m      <= 11'd1;
        rstate <= R_OUT;
      end
    end else begin
      source_valid <= 1'b1;
      source_sop   <= (m == 11'd0);
      source_eop   <= rd_last;
      if (rd_last) begin
        rsel <= ~rsel;
        m    <= '0;
        if (full[~rsel]) nr_m1 <= nb_m1[~rsel];
        else rstate <= R_IDLE;
      end else m <= m + 11'd1;
    end
  end
  assign source_real = source_valid ? q : '0;
`ifdef IDCT_REORDER_ERR_EN
  localparam logic signed [wDataIn-1:0] IM_MAX = wDataIn'(2);
  localparam logic signed [wDataIn-1:0] IM_MIN = -IM_MAX;
  logic err_ev;
  assign err_ev = (sop_beat & ((wstate == W_FILL) | full[wsel]))
                | (sink_valid & sink_eop & ~last)
                | (we & (($signed(sink_imag) > IM_MAX) | ($signed(sink_imag) < IM_MIN)));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) source_error <= 1'b0;
    else if (err_ev) source_error <= 1'b1;
  end
`else
  logic unused_err;
  assign unused_err = ^{sink_imag, sink_eop};
`endif
endmodule

// File: tb/tb_idct_out_reorder.sv
// tb_idct_out_reorder: scoreboard bench for idct_out_reorder
module tb_idct_out_reorder;
  logic clk = 1'b0, rst = 1'b1;
  logic sink_valid = 0, sink_sop = 0, sink_eop = 0;
  logic [17:0] sink_real = '0, sink_imag = '0;
  logic [11:0] fftpts_in = '0;
  logic source_valid, source_sop, source_eop;
  logic [17:0] source_real;
`ifdef IDCT_REORDER_ERR_EN
  logic source_error;
`endif
  logic [19:0] sb[$];
  int lat_q[$];
  int vectors = 0, errors = 0, cyc = 0, run = 0, max_run = 0;
  bit mid = 0;
  idct_out_reorder dut (
    .clk(clk), .rst(rst), .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag), .fftpts_in(fftpts_in),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real)
`ifdef IDCT_REORDER_ERR_EN
    , .source_error(source_error)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic push_block(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      int v;
      v = (i % 2) ? base + n - 1 - i / 2 : base + i / 2;
      sb.push_back({18'(v), i == 0, i == n - 1});
    end
  endtask
  task automatic send(input int nf, input int n, input int base, input bit gaps);
    for (int k = 0; k < n; k++) begin
      while (gaps && $urandom_range(1, 0) == 1) @(negedge clk);
      sink_valid = 1; sink_sop = (k == 0); sink_eop = (k == n - 1);
      sink_real = 18'(base + k); fftpts_in = 12'(nf);
      if (k == n - 1) begin
        push_block(n, base);
        lat_q.push_back(cyc + 2);
      end
      @(negedge clk);
      sink_valid = 0; sink_sop = 0; sink_eop = 0;
    end
  endtask
  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 12000) begin
      @(negedge clk);
      i++;
    end
    chk("drain", sb.size(), 0);
    repeat (4) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      mid = 0;
      run = 0;
    end else begin
      if (mid) chk("contig", source_valid, 1);
      if (source_valid) begin
        run++;
        if (run > max_run) max_run = run;
        vectors++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out got %0h want none", source_real);
        end
        if (sb.size() != 0) chk("data", {source_real, source_sop, source_eop}, sb.pop_front());
        if (source_sop && lat_q.size() != 0) chk("latency", cyc, lat_q.pop_front());
      end else run = 0;
      mid = source_valid && !source_eop;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", source_valid, 0);
    chk("rst_sop", source_sop, 0);
    chk("rst_eop", source_eop, 0);
    chk("rst_real", source_real, 0);
    rst = 0;
    @(negedge clk);
    send(32, 32, 0, 0);
    drain();
    max_run = 0;
    send(2048, 2048, 0, 0);
    send(2048, 2048, 4096, 0);
    send(2048, 2048, 8192, 0);
    drain();
    chk("b2b_run", max_run, 6144);
    send(64, 64, 500, 1);
    drain();
    send(100, 2048, 20000, 0);
    drain();
    for (int k = 0; k < 10; k++) begin
      sink_valid = 1; sink_sop = (k == 0); sink_real = 18'(7000 + k); fftpts_in = 12'd32;
      @(negedge clk);
    end
    sink_valid = 0; sink_sop = 0;
    send(32, 32, 3000, 0);
    drain();
`ifdef IDCT_REORDER_ERR_EN
    chk("err_sticky", source_error, 1);
`endif
    send(128, 128, 40000, 0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", source_valid, 0);
    chk("mid_rst_sop", source_sop, 0);
    chk("mid_rst_eop", source_eop, 0);
    chk("mid_rst_real", source_real, 0);
    sb.delete();
    lat_q.delete();
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
`ifdef IDCT_REORDER_ERR_EN
    chk("err_cleared", source_error, 0);
`endif
    send(32, 32, 60000, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
